hdd_sector_ctrl: RTL
====================

HDD_SECTOR_CTRL -- requirements
Module: hdd_sector_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 24'd14_000_000, ack-wait watchdog limit in CLK_14M cycles (used only with HDD_TIMEOUT_EN).
REQ-002 CLK_14M  in  1  sole clock; all logic rising-edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 hdd_read / hdd_write  in  1 each  one-cycle command pulses from the HDD register block.
REQ-005 sector  in  16  block number, sampled on an accepted pulse.
REQ-006 hdd_mounted  in  1  image present.
REQ-007 sd_ack  in  1  host transfer-window strobe, same clock domain.
REQ-008 sd_buff_addr  in  9; sd_buff_dout  in  8; sd_buff_wr  in  1  host byte stream.
REQ-009 ram_do  in  8  sector-buffer read data (port A).
REQ-010 sd_lba  out  32  {16'h0, latched sector}.
REQ-011 sd_rd / sd_wr  out  1 each  host block requests.
REQ-012 sd_buff_din  out  8  equals ram_do.
REQ-013 ram_addr  out  9; ram_di  out  8; ram_we  out  1  sector-buffer port A.
REQ-014 cpu_halt  out  1  stalls the 6502 while busy.
REQ-015 err  out  1  sticky failure flag.

Function
REQ-016 FSM states: IDLE, REQ, XFER, DONE, ERR.
REQ-017 IDLE: a pulse while hdd_mounted=1 latches sector and op (read/write); the next cycle enters REQ with cpu_halt=1, err=0, and sd_rd (read) or sd_wr (write) =1.
REQ-018 Simultaneous hdd_read and hdd_write: read wins; write discarded.
REQ-019 Pulse while hdd_mounted=0: ignored; err set; no halt.
REQ-020 Pulses outside IDLE: ignored, no state change.
REQ-021 REQ: hold request until sd_ack=1; on that cycle drop sd_rd/sd_wr and enter XFER.
REQ-022 REQ with hdd_mounted falling: drop request, set err, enter ERR.
REQ-023 XFER: ram_addr=sd_buff_addr; ram_di=sd_buff_dout; ram_we=sd_buff_wr&sd_ack only for read ops; ram_we=0 for write ops.
REQ-024 XFER exits to DONE on the cycle sd_ack=0; mount loss inside XFER is not aborted.
REQ-025 DONE: one cycle, cpu_halt=0, return to IDLE; total overhead 2 cycles beyond host ack window.
REQ-026 ERR: one cycle, cpu_halt=0, requests 0, return to IDLE; err remains until next accepted command.
REQ-027 Outside XFER: ram_we=0, ram_addr=0, ram_di=0.
REQ-028 sd_lba stable from REQ entry to IDLE return.

Reset
REQ-029 RESET_N=0 asynchronously forces IDLE, sd_lba=0, sd_rd=0, sd_wr=0, ram_we=0, ram_addr=0, ram_di=0, cpu_halt=0, err=0, watchdog=0.
REQ-030 Reset mid-transfer abandons the op; no buffer write occurs while RESET_N=0.

Configuration
REQ-031 HDD_TIMEOUT_EN defined: 24-bit watchdog clears on REQ entry and on each sd_buff_wr; reaching TIMEOUT_CYCLES in REQ or XFER drops requests, sets err, enters ERR.
REQ-032 HDD_TIMEOUT_EN undefined: no watchdog logic; REQ/XFER wait indefinitely.

Structure
REQ-033 Package hdd_pkg holds FSM state enum, op encoding (OP_READ, OP_WRITE), SECTOR_BYTES=512, default TIMEOUT_CYCLES.
REQ-034 No sub-module; watchdog is an inline counter.

Verification
REQ-035 Read: sector=16'h0123, pulse hdd_read, ack after 10 cycles, 512 sd_buff_wr bytes -> sd_lba=32'h0000_0123, sd_rd high until ack, 512 ram_we, cpu_halt low 2 cycles after ack falls.
REQ-036 Write: pulse hdd_write, ack window -> sd_wr asserted, ram_we never high, sd_buff_din tracks ram_do per ram_addr.
REQ-037 Simultaneous hdd_read+hdd_write -> only sd_rd asserted; second pulse during XFER ignored.
REQ-038 hdd_mounted=0 then hdd_read -> err=1, cpu_halt stays 0; mount drop in REQ -> ERR, err=1, sd_rd=0.
REQ-039 HDD_TIMEOUT_EN, TIMEOUT_CYCLES=100, no ack -> ERR at cycle 100, err=1, halt released; undefined -> halt held 1000+ cycles.
REQ-040 RESET_N low mid-XFER -> all outputs 0 immediately, state IDLE, next read succeeds.

Source files
------------

// File: rtl/hdd_pkg.sv
// Shared types and constants for the HDD sector controller: FSM states,
// operation encoding, sector buffer geometry and the default ack-wait limit.
package hdd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_XFER = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int SECTOR_BYTES = 512;
    localparam int BUF_AW       = $clog2(SECTOR_BYTES);

    localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd14_000_000;

endpackage

// File: rtl/hdd_sector_ctrl_if.sv
// Command, host block-transfer and sector-buffer signals of the HDD sector
// controller; slave is the controller, master is its environment.
interface hdd_sector_ctrl_if;
    import hdd_pkg::*;

    logic              hdd_read;
    logic              hdd_write;
    logic [15:0]       sector;
    logic              hdd_mounted;
    logic              sd_ack;
    logic [BUF_AW-1:0] sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        ram_do;

    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic [7:0]        sd_buff_din;
    logic [BUF_AW-1:0] ram_addr;
    logic [7:0]        ram_di;
    logic              ram_we;
    logic              cpu_halt;
    logic              err;

    modport slave (
        input  hdd_read, hdd_write, sector, hdd_mounted, sd_ack,
               sd_buff_addr, sd_buff_dout, sd_buff_wr, ram_do,
        output sd_lba, sd_rd, sd_wr, sd_buff_din, ram_addr, ram_di,
               ram_we, cpu_halt, err
    );

    modport master (
        output hdd_read, hdd_write, sector, hdd_mounted, sd_ack,
               sd_buff_addr, sd_buff_dout, sd_buff_wr, ram_do,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, ram_addr, ram_di,
               ram_we, cpu_halt, err
    );

endinterface

// File: rtl/hdd_sector_ctrl.sv
// Sector transfer controller bridging the HDD register block and the host block
// interface. Define HDD_TIMEOUT_EN to add the ack-wait watchdog.
module hdd_sector_ctrl
    import hdd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              CLK_14M,
    input  logic              RESET_N,
    hdd_sector_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] sector_q, sector_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic        err_q, err_d;
`ifdef HDD_TIMEOUT_EN
    logic [23:0] wdog_q, wdog_d;
    logic        wdog_expired;

    assign wdog_expired = (wdog_q >= (TIMEOUT_CYCLES - 24'd1));
`endif

    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_READ;
            sector_q <= 16'h0000;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef HDD_TIMEOUT_EN
            wdog_q   <= 24'd0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sector_q <= sector_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
            err_q    <= err_d;
`ifdef HDD_TIMEOUT_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    // Mount loss is only fatal before the host opens its window; once bytes flow we let it finish.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sector_d = sector_q;
        sd_rd_d  = sd_rd_q;
        sd_wr_d  = sd_wr_q;
        err_d    = err_q;
`ifdef HDD_TIMEOUT_EN
        wdog_d   = wdog_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.hdd_read || bus.hdd_write) begin
                    if (bus.hdd_mounted) begin
                        op_d     = bus.hdd_read ? OP_READ : OP_WRITE;
                        sector_d = bus.sector;
                        sd_rd_d  = bus.hdd_read;
                        sd_wr_d  = ~bus.hdd_read;
                        err_d    = 1'b0;
                        state_d  = ST_REQ;
`ifdef HDD_TIMEOUT_EN
                        wdog_d   = 24'd0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (!bus.hdd_mounted) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_XFER;
`ifdef HDD_TIMEOUT_EN
                end else if (wdog_expired) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wdog_d = wdog_q + 24'd1;
`endif
                end
            end
            ST_XFER: begin
                if (!bus.sd_ack) begin
                    state_d = ST_DONE;
`ifdef HDD_TIMEOUT_EN
                end else if (bus.sd_buff_wr) begin
                    wdog_d = 24'd0;
                end else if (wdog_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wdog_d = wdog_q + 24'd1;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR: begin
                sd_rd_d = 1'b0;
                sd_wr_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic in_xfer;
    assign in_xfer = (state_q == ST_XFER);

    assign bus.sd_lba      = {16'h0000, sector_q};
    assign bus.sd_rd       = sd_rd_q;
    assign bus.sd_wr       = sd_wr_q;
    assign bus.err         = err_q;
    assign bus.cpu_halt    = (state_q == ST_REQ) || in_xfer;
    assign bus.sd_buff_din = bus.ram_do;

    // The buffer is only written when the host is delivering a read sector.
    assign bus.ram_we   = in_xfer && (op_q == OP_READ) && bus.sd_buff_wr && bus.sd_ack;
    assign bus.ram_addr = in_xfer ? bus.sd_buff_addr : '0;
    assign bus.ram_di   = in_xfer ? bus.sd_buff_dout : 8'h00;

endmodule
